// File: rtl/apb_transfer_fsm_if.sv
// Bundle of the bridge-side request/FIFO signals and the APB bus signals
// handled by apb_transfer_fsm. Clock and reset are kept outside.
interface apb_transfer_fsm_if #(
    parameter int AHB_AW = 32,
    parameter int AHB_DW = 32
);
    // Bridge request side
    logic              i_start_transfer;
    logic [AHB_AW-1:0] i_haddr;
    logic [2:0]        i_hsize;

    // Write FIFO side
    logic              i_fifo_empty;
    logic [AHB_DW-1:0] i_fifo_wdata;
    logic              o_fifo_pop;

    // APB bus
    logic              i_pready;
    logic              i_pslverr;
    logic [AHB_DW-1:0] i_prdata;
    logic              o_psel;
    logic              o_penable;
    logic              o_pwrite;
    logic [AHB_AW-1:0] o_paddr;
    logic [AHB_DW-1:0] o_pwdata;
    logic [3:0]        o_pstrb;

    // AHB-side status
    logic [AHB_DW-1:0] o_rdata;
    logic              o_rdata_valid;
    logic              o_hready;
    logic              o_error;

    // View of the transfer FSM (the APB master)
    modport master (
        input  i_start_transfer, i_haddr, i_hsize,
        input  i_fifo_empty, i_fifo_wdata,
        input  i_pready, i_pslverr, i_prdata,
        output o_fifo_pop,
        output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
        output o_rdata, o_rdata_valid, o_hready, o_error
    );

    // View of everything around the FSM (bridge logic, FIFO, APB slave)
    modport slave (
        output i_start_transfer, i_haddr, i_hsize,
        output i_fifo_empty, i_fifo_wdata,
        output i_pready, i_pslverr, i_prdata,
        input  o_fifo_pop,
        input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
        input  o_rdata, o_rdata_valid, o_hready, o_error
    );
endinterface

// File: rtl/apb_transfer_fsm.sv
// APB transfer sequencer for the AHB-to-APB bridge: runs SETUP/ACCESS for
// each start pulse, holds one pending request while busy, pops the write
// FIFO on write completion, returns read data and flags slave errors and
// wait-state timeouts. AHB_DW must be 32 (4 byte strobes).
module apb_transfer_fsm #(
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32,
    parameter int TIMEOUT = 16
) (
    input logic               hclk,
    input logic               rst,
    apb_transfer_fsm_if.master bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT != 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t            state_q;
    logic              pending_q;
    logic [AHB_AW-1:0] pend_addr_q;
    logic [2:0]        pend_size_q;
    logic              pend_write_q;
    logic [CW-1:0]     cnt_q;

    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [AHB_AW-1:0] paddr_q;
    logic [AHB_DW-1:0] pwdata_q;
    logic [3:0]        pstrb_q;
    logic [AHB_DW-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              hready_q;
    logic              error_q;
    logic              fifo_pop_q;

    logic              acc_done;
    logic              acc_tmo;
    logic              finish;
    logic              load;
    logic [AHB_AW-1:0] ld_addr;
    logic [2:0]        ld_size;
    logic              ld_write;

    function automatic logic [3:0] strb_f(input logic [2:0] size,
                                          input logic [1:0] a,
                                          input logic       wr);
        logic [3:0] s;
        case (size)
            3'd0:    s = 4'b0001 << a;
            3'd1:    s = 4'b0011 << {a[1], 1'b0};
            default: s = 4'hF;
        endcase
        return wr ? s : 4'h0;
    endfunction

    // Completion/abort detection and the source of the next transfer to load
    always_comb begin
        acc_done = (state_q == ACCESS) && bus.i_pready;
        acc_tmo  = (TIMEOUT != 0) && (state_q == ACCESS) && !bus.i_pready
                   && (cnt_q == TO_LAST);
        finish   = acc_done || acc_tmo;
        // IDLE never holds a pending request, so one mux serves every load
        load     = ((state_q == IDLE) && bus.i_start_transfer)
                   || (finish && (pending_q || bus.i_start_transfer));
        ld_addr  = pending_q ? pend_addr_q  : bus.i_haddr;
        ld_size  = pending_q ? pend_size_q  : bus.i_hsize;
        ld_write = pending_q ? pend_write_q : ~bus.i_fifo_empty;
    end

    // FSM with registered APB, FIFO and AHB-side outputs
    always_ff @(posedge hclk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_size_q   <= '0;
            pend_write_q  <= 1'b0;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            hready_q      <= 1'b1;
            error_q       <= 1'b0;
            fifo_pop_q    <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            error_q       <= 1'b0;
            fifo_pop_q    <= 1'b0;

            // Status pulses of the transfer ending this cycle
            if (finish) begin
                fifo_pop_q <= pwrite_q;
                if (acc_done) begin
                    if (!pwrite_q) begin
                        rdata_q       <= bus.i_prdata;
                        rdata_valid_q <= 1'b1;
                    end
                    error_q <= bus.i_pslverr;
                end else begin
                    error_q <= 1'b1;
                end
            end

            if (load) begin
                // Write data is taken at SETUP entry, also for a pending write
                state_q   <= SETUP;
                paddr_q   <= ld_addr;
                pwrite_q  <= ld_write;
                pwdata_q  <= bus.i_fifo_wdata;
                pstrb_q   <= strb_f(ld_size, ld_addr[1:0], ld_write);
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                hready_q  <= 1'b0;
                cnt_q     <= '0;
                pending_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        hready_q <= 1'b1;
                    end
                    SETUP: begin
                        state_q   <= ACCESS;
                        penable_q <= 1'b1;
                    end
                    ACCESS: begin
                        if (finish) begin
                            state_q   <= IDLE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            hready_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end

            // Start while busy goes to the one-deep pending slot
            if ((state_q != IDLE) && !finish && bus.i_start_transfer && !pending_q) begin
                pending_q    <= 1'b1;
                pend_addr_q  <= bus.i_haddr;
                pend_size_q  <= bus.i_hsize;
                pend_write_q <= ~bus.i_fifo_empty;
            end
        end
    end

    assign bus.o_psel        = psel_q;
    assign bus.o_penable     = penable_q;
    assign bus.o_pwrite      = pwrite_q;
    assign bus.o_paddr       = paddr_q;
    assign bus.o_pwdata      = pwdata_q;
    assign bus.o_pstrb       = pstrb_q;
    assign bus.o_rdata       = rdata_q;
    assign bus.o_rdata_valid = rdata_valid_q;
    assign bus.o_hready      = hready_q;
    assign bus.o_error       = error_q;
    assign bus.o_fifo_pop    = fifo_pop_q;

endmodule

// File: tb/tb_apb_transfer_fsm.sv
module tb_apb_transfer_fsm;

  logic hclk;
  logic rst;

  apb_transfer_fsm_if #(.AHB_AW(32), .AHB_DW(32)) bus ();

  apb_transfer_fsm #(
    .AHB_AW (32),
    .AHB_DW (32),
    .TIMEOUT(4)
  ) dut (
    .hclk(hclk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rv;
    logic        pop;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic push(input logic rv, input logic pop, input logic err, input logic [31:0] rd);
    exp_t e;
    e.rv = rv; e.pop = pop; e.err = err; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge hclk);
    @(negedge hclk);
    if (bus.o_rdata_valid || bus.o_fifo_pop || bus.o_error) begin
      if (exp_q.size() == 0) begin
        checks++;
        if ({bus.o_rdata_valid, bus.o_fifo_pop, bus.o_error} !== 3'b000) begin
          errors++;
          $error("FAIL sb_unexpected: observed=%0h expected=0", {bus.o_rdata_valid, bus.o_fifo_pop, bus.o_error});
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.o_rdata_valid, bus.o_fifo_pop, bus.o_error} !== {e.rv, e.pop, e.err}) begin
          errors++;
          $error("FAIL sb_flags: observed=%0h expected=%0h", {bus.o_rdata_valid, bus.o_fifo_pop, bus.o_error}, {e.rv, e.pop, e.err});
        end
        if (e.rv) begin
          checks++;
          if (bus.o_rdata !== e.rdata) begin
            errors++;
            $error("FAIL sb_rdata: observed=%0h expected=%0h", bus.o_rdata, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [2:0] sz, input logic empty, input logic [31:0] wd);
    bus.i_start_transfer = 1'b1;
    bus.i_haddr          = a;
    bus.i_hsize          = sz;
    bus.i_fifo_empty     = empty;
    bus.i_fifo_wdata     = wd;
  endtask

  initial begin
    int acc;
    rst                  = 1'b1;
    bus.i_start_transfer = 1'b0;
    bus.i_haddr          = '0;
    bus.i_hsize          = '0;
    bus.i_fifo_empty     = 1'b1;
    bus.i_fifo_wdata     = '0;
    bus.i_pready         = 1'b0;
    bus.i_pslverr        = 1'b0;
    bus.i_prdata         = '0;
    tick();
    tick();
    checks++; if (bus.o_psel !== 1'b0) begin errors++; $error("FAIL rst_psel: observed=%0h expected=0", bus.o_psel); end
    checks++; if (bus.o_penable !== 1'b0) begin errors++; $error("FAIL rst_penable: observed=%0h expected=0", bus.o_penable); end
    checks++; if (bus.o_hready !== 1'b1) begin errors++; $error("FAIL rst_hready: observed=%0h expected=1", bus.o_hready); end
    checks++; if ({bus.o_pwrite, bus.o_pstrb, bus.o_paddr, bus.o_rdata} !== '0) begin errors++; $error("FAIL rst_outs: observed=%0h expected=0", {bus.o_pwrite, bus.o_pstrb, bus.o_paddr, bus.o_rdata}); end
    rst = 1'b0;
    tick();

    // 1: word read, zero wait states
    start(32'h1000_0004, 3'd2, 1'b1, 32'h0);
    push(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b100) begin errors++; $error("FAIL s1_setup: observed=%0h expected=4", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    checks++; if (bus.o_paddr !== 32'h1000_0004) begin errors++; $error("FAIL s1_paddr: observed=%0h expected=10000004", bus.o_paddr); end
    checks++; if ({bus.o_pwrite, bus.o_pstrb} !== 5'b0_0000) begin errors++; $error("FAIL s1_pwrite_pstrb: observed=%0h expected=0", {bus.o_pwrite, bus.o_pstrb}); end
    bus.i_start_transfer = 1'b0;
    bus.i_pready = 1'b1;
    bus.i_prdata = 32'hDEAD_BEEF;
    tick();
    checks++; if ({bus.o_psel, bus.o_penable} !== 2'b11) begin errors++; $error("FAIL s1_access: observed=%0h expected=3", {bus.o_psel, bus.o_penable}); end
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b001) begin errors++; $error("FAIL s1_done: observed=%0h expected=1", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s1_drain: observed=%0d expected=0", exp_q.size()); end
    bus.i_pready = 1'b0;
    tick();

    // 2: byte write, two wait states
    start(32'h2000_0003, 3'd0, 1'b0, 32'h1122_3344);
    push(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checks++; if ({bus.o_pwrite, bus.o_pstrb} !== 5'b1_1000) begin errors++; $error("FAIL s2_pwrite_pstrb: observed=%0h expected=18", {bus.o_pwrite, bus.o_pstrb}); end
    checks++; if (bus.o_pwdata !== 32'h1122_3344) begin errors++; $error("FAIL s2_pwdata: observed=%0h expected=11223344", bus.o_pwdata); end
    bus.i_start_transfer = 1'b0;
    bus.i_fifo_wdata = 32'h9999_9999;
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b110) begin errors++; $error("FAIL s2_acc1: observed=%0h expected=6", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b110) begin errors++; $error("FAIL s2_acc2: observed=%0h expected=6", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b110) begin errors++; $error("FAIL s2_acc3: observed=%0h expected=6", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    checks++; if ({bus.o_paddr, bus.o_pwdata} !== {32'h2000_0003, 32'h1122_3344}) begin errors++; $error("FAIL s2_stable: observed=%0h expected=2000000311223344", {bus.o_paddr, bus.o_pwdata}); end
    bus.i_pready = 1'b1;
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b001) begin errors++; $error("FAIL s2_done: observed=%0h expected=1", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    bus.i_pready = 1'b0;
    tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s2_drain: observed=%0d expected=0", exp_q.size()); end
    checks++; if (bus.o_rdata !== 32'hDEAD_BEEF) begin errors++; $error("FAIL s2_rdata_hold: observed=%0h expected=deadbeef", bus.o_rdata); end

    // 3: half write with slave error
    start(32'h2000_0002, 3'd1, 1'b0, 32'hA5A5_A5A5);
    push(1'b0, 1'b1, 1'b1, 32'h0);
    tick();
    checks++; if (bus.o_pstrb !== 4'b1100) begin errors++; $error("FAIL s3_pstrb: observed=%0h expected=c", bus.o_pstrb); end
    bus.i_start_transfer = 1'b0;
    bus.i_pready = 1'b1;
    bus.i_pslverr = 1'b1;
    tick();
    tick();
    bus.i_pready = 1'b0;
    bus.i_pslverr = 1'b0;
    tick();
    checks++; if (bus.o_error !== 1'b0) begin errors++; $error("FAIL s3_error_pulse: observed=%0h expected=0", bus.o_error); end
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s3_drain: observed=%0d expected=0", exp_q.size()); end

    // 4: read timeout, pready never arrives
    start(32'h3000_0000, 3'd2, 1'b1, 32'h0);
    push(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    bus.i_start_transfer = 1'b0;
    acc = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      if (!bus.o_penable) break;
      acc++;
    end
    checks++; if (acc !== 4) begin errors++; $error("FAIL s4_access_cycles: observed=%0d expected=4", acc); end
    checks++; if ({bus.o_psel, bus.o_hready, bus.o_rdata_valid} !== 3'b010) begin errors++; $error("FAIL s4_abort: observed=%0h expected=2", {bus.o_psel, bus.o_hready, bus.o_rdata_valid}); end
    tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s4_drain: observed=%0d expected=0", exp_q.size()); end

    // 5: back-to-back, second start during ACCESS of a read
    start(32'h4000_0000, 3'd2, 1'b1, 32'h0);
    push(1'b1, 1'b0, 1'b0, 32'h55AA_55AA);
    tick();
    bus.i_start_transfer = 1'b0;
    tick();
    start(32'h4000_0010, 3'd2, 1'b0, 32'hCAFE_F00D);
    push(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checks++; if ({bus.o_penable, bus.o_hready} !== 2'b10) begin errors++; $error("FAIL s5_acc_hready: observed=%0h expected=2", {bus.o_penable, bus.o_hready}); end
    bus.i_start_transfer = 1'b0;
    bus.i_pready = 1'b1;
    bus.i_prdata = 32'h55AA_55AA;
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b100) begin errors++; $error("FAIL s5_setup2: observed=%0h expected=4", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    checks++; if (bus.o_paddr !== 32'h4000_0010) begin errors++; $error("FAIL s5_paddr2: observed=%0h expected=40000010", bus.o_paddr); end
    checks++; if ({bus.o_pwrite, bus.o_pstrb, bus.o_pwdata} !== {1'b1, 4'hF, 32'hCAFE_F00D}) begin errors++; $error("FAIL s5_wr2: observed=%0h", {bus.o_pwrite, bus.o_pstrb, bus.o_pwdata}); end
    tick();
    checks++; if (bus.o_hready !== 1'b0) begin errors++; $error("FAIL s5_acc2_hready: observed=%0h expected=0", bus.o_hready); end
    tick();
    checks++; if ({bus.o_psel, bus.o_hready} !== 2'b01) begin errors++; $error("FAIL s5_done: observed=%0h expected=1", {bus.o_psel, bus.o_hready}); end
    bus.i_pready = 1'b0;
    tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s5_drain: observed=%0d expected=0", exp_q.size()); end

    // 7: start in the completion cycle goes straight to SETUP
    start(32'h6000_0008, 3'd2, 1'b1, 32'h0);
    push(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    tick();
    bus.i_start_transfer = 1'b0;
    bus.i_pready = 1'b1;
    bus.i_prdata = 32'h0BAD_F00D;
    tick();
    start(32'h6000_0001, 3'd0, 1'b0, 32'h7777_0000);
    push(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b100) begin errors++; $error("FAIL s7_setup: observed=%0h expected=4", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    checks++; if ({bus.o_paddr, bus.o_pstrb} !== {32'h6000_0001, 4'b0010}) begin errors++; $error("FAIL s7_addr_strb: observed=%0h expected=600000012", {bus.o_paddr, bus.o_pstrb}); end
    bus.i_start_transfer = 1'b0;
    tick();
    tick();
    bus.i_pready = 1'b0;
    tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s7_drain: observed=%0d expected=0", exp_q.size()); end

    // 6: reset during ACCESS with a pending request
    start(32'h5000_0000, 3'd2, 1'b0, 32'h1357_9BDF);
    tick();
    bus.i_start_transfer = 1'b0;
    tick();
    start(32'h5000_0004, 3'd2, 1'b1, 32'h0);
    tick();
    bus.i_start_transfer = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_hready} !== 3'b001) begin errors++; $error("FAIL s6_rst: observed=%0h expected=1", {bus.o_psel, bus.o_penable, bus.o_hready}); end
    checks++; if (bus.o_rdata !== '0) begin errors++; $error("FAIL s6_rst_rdata: observed=%0h expected=0", bus.o_rdata); end
    rst = 1'b0;
    tick();
    tick();
    checks++; if ({bus.o_psel, bus.o_hready} !== 2'b01) begin errors++; $error("FAIL s6_no_pending: observed=%0h expected=1", {bus.o_psel, bus.o_hready}); end
    start(32'h1000_0004, 3'd2, 1'b1, 32'h0);
    push(1'b1, 1'b0, 1'b0, 32'h1234_5678);
    tick();
    checks++; if ({bus.o_psel, bus.o_penable, bus.o_paddr} !== {2'b10, 32'h1000_0004}) begin errors++; $error("FAIL s6_setup: observed=%0h", {bus.o_psel, bus.o_penable, bus.o_paddr}); end
    bus.i_start_transfer = 1'b0;
    bus.i_pready = 1'b1;
    bus.i_prdata = 32'h1234_5678;
    tick();
    checks++; if ({bus.o_psel, bus.o_penable} !== 2'b11) begin errors++; $error("FAIL s6_access: observed=%0h expected=3", {bus.o_psel, bus.o_penable}); end
    tick();
    bus.i_pready = 1'b0;
    tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL s6_drain: observed=%0d expected=0", exp_q.size()); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
